count_event_monitor: RTL and testbench

- Downstream consumer of the up/down step counter (steps of ±1/±2, width N).
- Samples the counter's count output every cycle and classifies each transition as hold, legal step, wrap-around, or illegal step.
- Wrap and error events go into a small FIFO, drained over a valid/ready interface. Sticky status feeds the debug/status block.

---
 rtl/count_event_monitor.sv | 139 +++++++++++++
 tb/tb_count_event_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/count_event_monitor.sv
// Watches an up/down step counter, classifies each sampled transition and queues
// wrap and illegal-step events in a small FIFO drained over a valid/ready port.
module count_event_monitor #(
    parameter int N     = 3,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [N-1:0]  count_in,
    input  logic          clr,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [1:0]    evt_type,
    output logic [N-1:0]  evt_count,
    output logic [CW-1:0] wrap_cnt,
    output logic          overflow
);
    // Handshake: the head entry is offered while evt_valid=1 and is removed at a
    // clock edge where evt_valid && evt_ready; type/count hold steady until then.

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EVT_NONE = 2'b00,
        WRAP_UP  = 2'b01,
        WRAP_DN  = 2'b10,
        STEP_ERR = 2'b11
    } evt_e;

    localparam logic [N-1:0] STEP_P1 = N'(1);
    localparam logic [N-1:0] STEP_P2 = N'(2);
    localparam logic [N-1:0] STEP_M1 = {N{1'b1}};
    localparam logic [N-1:0] STEP_M2 = {{(N-1){1'b1}}, 1'b0};

    logic [N-1:0]   prev_q, prev_d;
    logic           primed_q, primed_d;
    logic [N+1:0]   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    fill_q;
    logic [CW-1:0]  wrap_cnt_q, wrap_cnt_d;
    logic           overflow_q, overflow_d;

    logic [N-1:0]   delta;
    evt_e           evt_d;
    logic           is_wrap;
    logic           fifo_full, fifo_empty;
    logic           pop, push, drop;
    logic [N+1:0]   head;

    assign delta = count_in - prev_q;

    always_comb begin
        evt_d = EVT_NONE;
        if (en && primed_q) begin
            if (delta == '0) begin
                evt_d = EVT_NONE;
            end else if (delta == STEP_P1 || delta == STEP_P2) begin
                if (count_in < prev_q) evt_d = WRAP_UP;
            end else if (delta == STEP_M1 || delta == STEP_M2) begin
                if (count_in > prev_q) evt_d = WRAP_DN;
            end else begin
                evt_d = STEP_ERR;
            end
        end
    end

    assign is_wrap    = (evt_d == WRAP_UP) || (evt_d == WRAP_DN);
    assign fifo_full  = (fill_q == (AW+1)'(DEPTH));
    assign fifo_empty = (fill_q == '0);
    assign pop        = !fifo_empty && evt_ready;
    // A full FIFO still accepts the new event when the head leaves on the same edge.
    assign push       = (evt_d != EVT_NONE) && (!fifo_full || pop);
    assign drop       = (evt_d != EVT_NONE) && fifo_full && !pop;

    always_comb begin
        prev_d   = prev_q;
        primed_d = 1'b0;
        if (en) begin
            prev_d   = count_in;
            primed_d = 1'b1;
        end
    end

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clr) begin
            wrap_cnt_d = is_wrap ? CW'(1) : '0;
        end else if (is_wrap && (wrap_cnt_q != {CW{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + CW'(1);
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (clr)  overflow_d = 1'b0;
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q     <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            wrap_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            wrap_cnt_q <= wrap_cnt_d;
            overflow_q <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                fill_q <= fill_q + (AW+1)'(1);
            end else if (pop && !push) begin
                fill_q <= fill_q - (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= {evt_d, count_in};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign evt_valid = !fifo_empty;
    assign evt_type  = fifo_empty ? 2'b00 : head[N+1:N];
    assign evt_count = fifo_empty ? '0 : head[N-1:0];
    assign wrap_cnt  = wrap_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed plus random bench for count_event_monitor: a reference model predicts
// events into exp_q, which is compared against the FIFO head as entries drain.
module tb_count_event_monitor;
    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk;
    logic          reset;
    logic          en;
    logic [N-1:0]  count_in;
    logic          clr;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_type;
    logic [N-1:0]  evt_count;
    logic [CW-1:0] wrap_cnt;
    logic          overflow;

    count_event_monitor #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .count_in  (count_in),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_type  (evt_type),
        .evt_count (evt_count),
        .wrap_cnt  (wrap_cnt),
        .overflow  (overflow)
    );

    // ---- clock/reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- scoreboard and reference model state ----
    logic [N+1:0] exp_q[$];
    logic [N-1:0] m_prev;
    bit           m_primed;
    int           m_wrap;
    bit           m_ovf;
    int           n_cmp;
    int           n_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        m_prev   = '0;
        m_primed = 1'b0;
        m_wrap   = 0;
        m_ovf    = 1'b0;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_type",  32'(evt_type),  32'd0);
        check("rst_count", 32'(evt_count), 32'd0);
        check("rst_wrap",  32'(wrap_cnt),  32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
    endtask

    // One clock: drive at negedge, check head before the edge, advance model,
    // then check status after the edge.
    task automatic step(input logic [N-1:0] c, input logic e, input logic r, input logic cl);
        logic [N-1:0] d;
        logic [1:0]   typ;
        logic [N+1:0] head;
        bit           pop_e;
        count_in  = c;
        en        = e;
        evt_ready = r;
        clr       = cl;
        pop_e     = r && (exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            check("head_valid", 32'(evt_valid), 32'd1);
            check("head_type",  32'(evt_type),  32'(head[N+1:N]));
            check("head_count", 32'(evt_count), 32'(head[N-1:0]));
        end else begin
            check("idle_valid", 32'(evt_valid), 32'd0);
        end
        typ = 2'b00;
        if (e) begin
            if (m_primed) begin
                d = c - m_prev;
                if (d == 0) typ = 2'b00;
                else if (d == 1 || d == 2) typ = (c < m_prev) ? 2'b01 : 2'b00;
                else if (d == 7 || d == 6) typ = (c > m_prev) ? 2'b10 : 2'b00;
                else typ = 2'b11;
            end
            m_prev   = c;
            m_primed = 1'b1;
        end else begin
            m_primed = 1'b0;
        end
        if (cl) begin
            m_wrap = (typ == 2'b01 || typ == 2'b10) ? 1 : 0;
            m_ovf  = 1'b0;
        end else if ((typ == 2'b01 || typ == 2'b10) && m_wrap < 255) begin
            m_wrap++;
        end
        if (pop_e) void'(exp_q.pop_front());
        if (typ != 2'b00) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({typ, c});
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("post_valid", 32'(evt_valid), 32'(exp_q.size() > 0));
        check("post_wrap",  32'(wrap_cnt),  32'(m_wrap));
        check("post_ovf",   32'(overflow),  32'(m_ovf));
    endtask

    // ---- directed and random sequence ----
    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b0; en = 1'b0; count_in = '0; clr = 1'b0; evt_ready = 1'b0;
        do_reset();

        // legal steps including a hold
        step(0, 1, 1, 0); step(0, 1, 1, 0); step(1, 1, 1, 0);
        step(3, 1, 1, 0); step(2, 1, 1, 0); step(0, 1, 1, 0);
        check("legal_no_evt", 32'(evt_valid), 32'd0);

        // wraps with handshake
        step(5, 0, 1, 0);
        step(5, 1, 1, 0); step(6, 1, 1, 0); step(0, 1, 1, 0);
        step(0, 1, 1, 0); step(1, 1, 1, 0); step(7, 1, 1, 0);
        step(7, 1, 1, 0);
        check("wrap_total", 32'(wrap_cnt), 32'd2);

        // illegal step 2 -> 5
        step(2, 0, 1, 0);
        step(2, 1, 1, 0); step(5, 1, 1, 0);
        step(5, 1, 1, 0);

        // overflow then drain
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(3, 1, 0, 0); step(6, 1, 0, 0); step(1, 1, 0, 0);
        step(4, 1, 0, 0); step(7, 1, 0, 0);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++) step(7, 1, 1, 0);
        step(7, 1, 1, 1);
        check("ovf_clr", 32'(overflow), 32'd0);

        // full FIFO with simultaneous push and pop
        step(2, 1, 0, 0); step(5, 1, 0, 0); step(0, 1, 0, 0); step(3, 1, 0, 0);
        step(6, 1, 1, 0);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) step(6, 1, 1, 0);

        // enable gap hides the jump
        step(2, 0, 1, 0);
        step(2, 1, 1, 0); step(5, 0, 1, 0); step(5, 0, 1, 0);
        step(5, 1, 1, 0); step(6, 1, 1, 0);
        check("gap_no_evt", 32'(evt_valid), 32'd0);

        // wrap counter saturation, then clr with concurrent wrap
        for (int i = 0; i < 262; i++) step((i % 2 == 0) ? 3'd7 : 3'd0, 1, 1, 0);
        check("wrap_sat", 32'(wrap_cnt), 32'd255);
        step(7, 1, 1, 1);
        check("clr_with_wrap", 32'(wrap_cnt), 32'd1);
        for (int i = 0; i < 3; i++) step(7, 1, 1, 0);

        // random traffic
        for (int i = 0; i < 200; i++)
            step(N'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));

        // reset mid-operation with two pending entries
        step(0, 0, 0, 0);
        step(0, 1, 0, 0); step(3, 1, 0, 0); step(6, 1, 0, 0);
        do_reset();
        step(4, 1, 1, 0);
        check("reprime_no_evt", 32'(evt_valid), 32'd0);
        step(5, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
